// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request port to asynchronous SRAM strobe sequencer (WE- and OE-controlled cycles).
// Latency: write 2+SETUP+PULSE+HOLD cycles, read 2+SETUP+RD cycles, accept edge to next possible accept.
// Backpressure: req_ready is high only in IDLE; requests seen while it is low are dropped, never queued.
module sram_ctrl #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int RD_CYC    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic          sram_oen,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i
);

  // A zero-length phase would collapse the strobe timing, so refuse to elaborate.
  generate
    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || RD_CYC < 1) begin : g_bad_param
      $error("sram_ctrl: SETUP_CYC, PULSE_CYC, HOLD_CYC and RD_CYC must all be at least 1");
    end
  endgenerate

  localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > RD_CYC) ? HOLD_CYC : RD_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RD_LD    = CW'(RD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    R_ACCESS = 3'd5,
    RECOVER  = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;

  logic cen_nxt;
  logic wen_nxt;
  logic oen_nxt;
  logic dq_oe_nxt;
  logic rsp_nxt;
  logic ready_nxt;

  assign accept = req_valid && req_ready;

  // State register and phase down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: each phase reloads the counter with its length minus one and leaves at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_we ? W_SETUP : R_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      W_SETUP: begin
        if (cnt == '0) begin
          state_nxt = W_PULSE;
          cnt_nxt   = PULSE_LD;
        end
      end
      W_PULSE: begin
        if (cnt == '0) begin
          state_nxt = W_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end
      W_HOLD: begin
        if (cnt == '0) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end
      end
      R_SETUP: begin
        if (cnt == '0) begin
          state_nxt = R_ACCESS;
          cnt_nxt   = RD_LD;
        end
      end
      R_ACCESS: begin
        if (cnt == '0) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
        end
      end
      RECOVER: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered strobes change on the same edge as the state.
  always_comb begin
    cen_nxt   = 1'b1;
    wen_nxt   = 1'b1;
    oen_nxt   = 1'b1;
    dq_oe_nxt = 1'b0;
    rsp_nxt   = 1'b0;
    ready_nxt = 1'b0;
    unique case (state_nxt)
      IDLE:     ready_nxt = 1'b1;
      W_SETUP: begin
        cen_nxt   = 1'b0;
        dq_oe_nxt = 1'b1;
      end
      W_PULSE: begin
        cen_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        dq_oe_nxt = 1'b1;
      end
      W_HOLD: begin
        cen_nxt   = 1'b0;
        dq_oe_nxt = 1'b1;
      end
      R_SETUP:  cen_nxt = 1'b0;
      R_ACCESS: begin
        cen_nxt = 1'b0;
        oen_nxt = 1'b0;
      end
      RECOVER:  rsp_nxt = 1'b1;
      default:  ready_nxt = 1'b0;
    endcase
  end

  // Registered SRAM-facing outputs, request capture and read-data sampling at the end of the access phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_cen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_oen   <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      req_ready  <= 1'b0;
    end else begin
      sram_cen   <= cen_nxt;
      sram_wen   <= wen_nxt;
      sram_oen   <= oen_nxt;
      sram_dq_oe <= dq_oe_nxt;
      rsp_valid  <= rsp_nxt;
      req_ready  <= ready_nxt;
      if (accept) begin
        sram_addr <= req_addr;
        sram_dq_o <= req_wdata;
      end
      if (state == R_ACCESS && cnt == '0) begin
        rsp_rdata <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: two controllers (default timing and a stretched-timing instance), each with its own SRAM model.
// Expected read data / response latency are queued at accept and compared when rsp_valid fires.
// Strobe widths, strobe ordering and address/data stability are watched on every falling clock edge.
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][7:0] req_addr, req_wdata, rsp_rdata, sram_addr, sram_dq_o, sram_dq_i;
  logic [1:0]      sram_cen, sram_wen, sram_oen, sram_dq_oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] gold [2][256];
  logic [7:0] exp_q [2][$];
  int         acc_q [2][$];
  int         lat_q [2][$];
  logic [7:0] last_rd [2];
  int         last_rsp [2];
  logic [7:0] cur_addr [2];
  logic [7:0] cur_wdata [2];
  logic       cur_we [2];

  sram_ctrl u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_cen(sram_cen[0]), .sram_wen(sram_wen[0]),
    .sram_oen(sram_oen[0]), .sram_dq_o(sram_dq_o[0]), .sram_dq_oe(sram_dq_oe[0]),
    .sram_dq_i(sram_dq_i[0])
  );

  sram_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2), .RD_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_cen(sram_cen[1]), .sram_wen(sram_wen[1]),
    .sram_oen(sram_oen[1]), .sram_dq_o(sram_dq_o[1]), .sram_dq_oe(sram_dq_oe[1]),
    .sram_dq_i(sram_dq_i[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int k, input int i);
    logic [7:0] key;
    key = (k == 0) ? 8'h5A : 8'hC3;
    return 8'(i) ^ key;
  endfunction

  // Cycles from accept to rsp_valid: SETUP+PULSE+HOLD for writes, SETUP+RD for reads.
  function automatic int lat(input int k, input bit we);
    if (k == 0) return we ? 3 : 3;
    return we ? 7 : 6;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_mon
    localparam int S = (k == 0) ? 1 : 2;
    localparam int P = (k == 0) ? 1 : 3;
    localparam int H = (k == 0) ? 1 : 2;
    localparam int R = (k == 0) ? 2 : 4;

    logic [7:0] mem [256];
    int   cen_run  = 0;
    int   wen_run  = 0;
    int   oen_run  = 0;
    logic prev_rsp = 1'b0;

    // SRAM model: drives dq while selected and output-enabled, writes while cen and wen are low.
    assign sram_dq_i[k] = sram_dq_oe[k] ? sram_dq_o[k] :
                          (!sram_cen[k] && !sram_oen[k]) ? mem[sram_addr[k]] : 8'h00;

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat(k, i);
      end else if (!sram_cen[k] && !sram_wen[k]) begin
        mem[sram_addr[k]] <= sram_dq_o[k];
      end
    end

    always @(negedge clk) begin
      if (rst) begin
        cen_run  = 0;
        wen_run  = 0;
        oen_run  = 0;
        prev_rsp = 1'b0;
      end else begin
        chk($sformatf("inv_wen_oen%0d", k), 32'(!sram_wen[k] && !sram_oen[k]), 0);
        chk($sformatf("inv_dqoe_oen%0d", k), 32'(sram_dq_oe[k] && !sram_oen[k]), 0);
        chk($sformatf("inv_strobe_cen%0d", k), 32'((!sram_wen[k] || !sram_oen[k]) && sram_cen[k]), 0);
        if (!sram_cen[k]) begin
          chk($sformatf("addr_stable%0d", k), 32'(sram_addr[k]), 32'(cur_addr[k]));
          if (cur_we[k]) chk($sformatf("wdata_stable%0d", k), 32'(sram_dq_o[k]), 32'(cur_wdata[k]));
        end

        if (!sram_cen[k]) cen_run++;
        else if (cen_run != 0) begin
          chk($sformatf("cen_low%0d", k), 32'(cen_run), cur_we[k] ? 32'(S + P + H) : 32'(S + R));
          cen_run = 0;
        end
        if (!sram_wen[k]) begin
          wen_run++;
          if (wen_run == 1) chk($sformatf("wen_start%0d", k), 32'(cen_run), 32'(S + 1));
        end else if (wen_run != 0) begin
          chk($sformatf("wen_low%0d", k), 32'(wen_run), 32'(P));
          wen_run = 0;
        end
        if (!sram_oen[k]) begin
          oen_run++;
          if (oen_run == 1) chk($sformatf("oen_start%0d", k), 32'(cen_run), 32'(S + 1));
        end else if (oen_run != 0) begin
          chk($sformatf("oen_low%0d", k), 32'(oen_run), 32'(R));
          oen_run = 0;
        end

        if (rsp_valid[k]) begin
          chk($sformatf("rsp_one_cycle%0d", k), 32'(prev_rsp), 0);
          if (exp_q[k].size() == 0) begin
            chk($sformatf("rsp_unexpected%0d", k), 1, 0);
          end else begin
            chk($sformatf("rdata%0d", k), 32'(rsp_rdata[k]), 32'(exp_q[k].pop_front()));
            chk($sformatf("latency%0d", k), 32'(cyc - acc_q[k].pop_front()), 32'(lat_q[k].pop_front()));
          end
          last_rsp[k] = cyc;
        end
        prev_rsp = rsp_valid[k];
      end
    end
  end

  // Present one request and wait (bounded) for acceptance; queue the expected response.
  task automatic issue(input int k, input bit we, input logic [7:0] a, input logic [7:0] d,
                       input bit keep, input bit gap_chk);
    bit ok;
    ok           = 1'b0;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("accept%0d", k), 32'(ok), 1);
    if (ok) begin
      @(posedge clk);
      #1;
      cur_addr[k]  = a;
      cur_wdata[k] = d;
      cur_we[k]    = we;
      if (we) begin
        gold[k][a] = d;
        exp_q[k].push_back(last_rd[k]);
      end else begin
        last_rd[k] = gold[k][a];
        exp_q[k].push_back(gold[k][a]);
      end
      acc_q[k].push_back(cyc);
      lat_q[k].push_back(lat(k, we));
      if (gap_chk) chk($sformatf("b2b_gap%0d", k), 32'(cyc - last_rsp[k]), 2);
    end
    if (!keep || !ok) req_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < 200; i++) begin
      if (exp_q[k].size() == 0) break;
      @(negedge clk);
    end
    chk($sformatf("drain%0d", k), 32'(exp_q[k].size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) gold[k][i] = pat(k, i);
      last_rd[k]   = 8'h00;
      last_rsp[k]  = 0;
      cur_addr[k]  = 8'h00;
      cur_wdata[k] = 8'h00;
      cur_we[k]    = 1'b0;
    end
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cen", 32'(sram_cen[0]), 1);
    chk("rst_wen", 32'(sram_wen[0]), 1);
    chk("rst_oen", 32'(sram_oen[0]), 1);
    chk("rst_dq_oe", 32'(sram_dq_oe[0]), 0);
    chk("rst_addr", 32'(sram_addr[0]), 0);
    chk("rst_dq_o", 32'(sram_dq_o[0]), 0);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("rst_rdata", 32'(rsp_rdata[0]), 0);
    chk("rst_ready0", 32'(req_ready[0]), 0);
    chk("rst_ready1", 32'(req_ready[1]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst0", 32'(req_ready[0]), 1);
    chk("ready_after_rst1", 32'(req_ready[1]), 1);

    // Write then read back.
    issue(0, 1'b1, 8'hAB, 8'hDE, 1'b0, 1'b0);
    issue(0, 1'b0, 8'hAB, 8'h00, 1'b0, 1'b0);
    drain(0);
    chk("rdata_AB", 32'(rsp_rdata[0]), 32'h0DE);

    // Four writes then four reads with req_valid held high.
    issue(0, 1'b1, 8'h38, 8'hAA, 1'b1, 1'b0);
    issue(0, 1'b1, 8'h55, 8'hFF, 1'b1, 1'b1);
    issue(0, 1'b1, 8'h77, 8'hDD, 1'b1, 1'b1);
    issue(0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1);
    issue(0, 1'b0, 8'h38, 8'h00, 1'b1, 1'b1);
    issue(0, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1);
    issue(0, 1'b0, 8'h77, 8'h00, 1'b1, 1'b1);
    issue(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drain(0);

    // Stretched timing instance.
    issue(1, 1'b1, 8'h3C, 8'h96, 1'b1, 1'b0);
    issue(1, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1);
    issue(1, 1'b0, 8'h3D, 8'h00, 1'b0, 1'b1);
    drain(1);

    // Reset in the middle of a write pulse.
    issue(0, 1'b1, 8'h40, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (!sram_wen[0]) break;
      @(negedge clk);
    end
    chk("reached_wpulse", 32'(sram_wen[0]), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cen", 32'(sram_cen[0]), 1);
    chk("abort_wen", 32'(sram_wen[0]), 1);
    chk("abort_oen", 32'(sram_oen[0]), 1);
    chk("abort_dq_oe", 32'(sram_dq_oe[0]), 0);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 0);
    chk("abort_ready", 32'(req_ready[0]), 0);
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      acc_q[k].delete();
      lat_q[k].delete();
      last_rd[k] = 8'h00;
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_abort", 32'(req_ready[0]), 1);
    issue(0, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0);
    drain(0);

    // A write leaves the last read data untouched.
    issue(0, 1'b1, 8'h20, 8'h5A, 1'b1, 1'b0);
    issue(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1);
    issue(0, 1'b1, 8'h10, 8'h12, 1'b0, 1'b1);
    drain(0);
    chk("rdata_kept", 32'(rsp_rdata[0]), 32'h05A);
    issue(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    drain(0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
